// File: rtl/pv_peak_tracker.sv
// pv_peak_tracker: captures the peak ADC sample and its servo position tag
// over a bounded sweep. A hysteresis margin rejects small noise-driven gains,
// and the committed peak (LV/LV_TAG) only changes when a non-empty sweep ends,
// so downstream control sees a stable value while the next sweep runs.
module pv_peak_tracker #(
  parameter int WIDTH     = 12,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 16,
  parameter int SWEEP_LEN = 180,
  parameter int HYST      = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             PV_VALID,
  input  logic [WIDTH-1:0] PV,
  input  logic [TAG_W-1:0] TAG,
  output logic [WIDTH-1:0] MAX_RUN,
  output logic [WIDTH-1:0] LV,
  output logic [TAG_W-1:0] LV_TAG,
  output logic             GT,
  output logic             BUSY,
  output logic             DONE,
  output logic             EMPTY,
  output logic [CNT_W-1:0] SAMPLE_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] lv_q, lv_d;
  logic [TAG_W-1:0] lv_tag_q, lv_tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             empty_q, empty_d;
  logic             capture;

  // Threshold test in one extra bit so MAX_RUN + HYST never wraps near full scale.
  function automatic logic exceeds(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m);
    logic [WIDTH:0] thr;
    thr = {1'b0, m} + (WIDTH+1)'(HYST);
    return ({1'b0, p} > thr);
  endfunction

  // Sample counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Next-state, capture decision and registered-output precomputation.
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    tag_d    = tag_q;
    lv_d     = lv_q;
    lv_tag_d = lv_tag_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_SWEEP;
          max_d   = '0;
          tag_d   = '0;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        if (PV_VALID) begin
          capture = (cnt_q == '0) || exceeds(PV, max_q);
          if (capture) begin
            max_d = PV;
            tag_d = TAG;
          end
          cnt_d = sat_inc(cnt_q);
        end
        // A sample arriving with STOP or completing the count is folded in first.
        if (STOP || ((SWEEP_LEN != 0) && PV_VALID && (cnt_d == CNT_W'(SWEEP_LEN)))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (cnt_q != '0) begin
          lv_d     = max_q;
          lv_tag_d = tag_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    gt_d    = capture;
    busy_d  = (state_d == S_SWEEP);
    done_d  = (state_d == S_DONE);
    empty_d = (state_d == S_DONE) && (cnt_d == '0);
  end

  // State and datapath registers; async reset discards any sweep in progress.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      max_q    <= '0;
      tag_q    <= '0;
      lv_q     <= '0;
      lv_tag_q <= '0;
      cnt_q    <= '0;
      gt_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      tag_q    <= tag_d;
      lv_q     <= lv_d;
      lv_tag_q <= lv_tag_d;
      cnt_q    <= cnt_d;
      gt_q     <= gt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      empty_q  <= empty_d;
    end
  end

  assign MAX_RUN    = max_q;
  assign LV         = lv_q;
  assign LV_TAG     = lv_tag_q;
  assign GT         = gt_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign EMPTY      = empty_q;
  assign SAMPLE_CNT = cnt_q;

endmodule

// File: tb/tb_pv_peak_tracker.sv
// Bench for pv_peak_tracker with SWEEP_LEN=5, HYST=4: directed vector table,
// hand-written corner sequences, then random sweeps against a list-based model.
module tb_pv_peak_tracker;

  localparam int WIDTH = 12;
  localparam int TAG_W = 8;
  localparam int CNT_W = 16;
  localparam int SLEN  = 5;
  localparam int HYST  = 4;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             START = 1'b0;
  logic             STOP = 1'b0;
  logic             PV_VALID = 1'b0;
  logic [WIDTH-1:0] PV = '0;
  logic [TAG_W-1:0] TAG = '0;
  logic [WIDTH-1:0] MAX_RUN, LV;
  logic [TAG_W-1:0] LV_TAG;
  logic             GT, BUSY, DONE, EMPTY;
  logic [CNT_W-1:0] SAMPLE_CNT;

  pv_peak_tracker #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W), .SWEEP_LEN(SLEN), .HYST(HYST)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .PV_VALID(PV_VALID),
    .PV(PV), .TAG(TAG), .MAX_RUN(MAX_RUN), .LV(LV), .LV_TAG(LV_TAG), .GT(GT),
    .BUSY(BUSY), .DONE(DONE), .EMPTY(EMPTY), .SAMPLE_CNT(SAMPLE_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] pv;
    logic [TAG_W-1:0] tag;
    logic             exp_gt;
    logic [WIDTH-1:0] exp_max;
  } vec_t;

  vec_t tbl[5];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Model state for random sweeps
  int m_max, m_tag, m_cnt, m_lv, m_lvtag;
  int gt_seen;

  initial begin
    tbl[0] = '{pv: 12'd100, tag: 8'd0, exp_gt: 1'b1, exp_max: 12'd100};
    tbl[1] = '{pv: 12'd103, tag: 8'd1, exp_gt: 1'b0, exp_max: 12'd100};
    tbl[2] = '{pv: 12'd105, tag: 8'd2, exp_gt: 1'b1, exp_max: 12'd105};
    tbl[3] = '{pv: 12'd200, tag: 8'd3, exp_gt: 1'b1, exp_max: 12'd200};
    tbl[4] = '{pv: 12'd204, tag: 8'd4, exp_gt: 1'b0, exp_max: 12'd200};

    // Reset state
    repeat (3) tick();
    chk("rst_lv", LV, 0);
    chk("rst_max", MAX_RUN, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_gt", GT, 0);
    chk("rst_cnt", SAMPLE_CNT, 0);
    RST_N = 1'b1;

    // Idle with valid toggling and full-scale PV: nothing must be captured
    PV = 12'hFFF;
    gt_seen = 0;
    for (int i = 0; i < 8; i++) begin
      PV_VALID = ~PV_VALID;
      tick();
      if (GT || BUSY) gt_seen++;
    end
    PV_VALID = 1'b0;
    chk("idle_gt_busy_pulses", gt_seen, 0);
    chk("idle_lv", LV, 0);
    chk("idle_max", MAX_RUN, 0);

    // Directed 5-sample sweep from the vector table
    START = 1'b1; tick(); START = 1'b0;
    chk("tbl_busy", BUSY, 1);
    gt_seen = 0;
    for (int i = 0; i < 5; i++) begin
      PV = tbl[i].pv; TAG = tbl[i].tag; PV_VALID = 1'b1;
      tick();
      chk($sformatf("tbl_gt%0d", i), GT, tbl[i].exp_gt);
      chk($sformatf("tbl_max%0d", i), MAX_RUN, tbl[i].exp_max);
      if (GT) gt_seen++;
      if (i < 4) chk($sformatf("tbl_nodone%0d", i), DONE, 0);
    end
    PV_VALID = 1'b0;
    chk("tbl_gt_count", gt_seen, 3);
    chk("tbl_done", DONE, 1);
    chk("tbl_empty", EMPTY, 0);
    chk("tbl_cnt", SAMPLE_CNT, 5);
    tick();
    chk("tbl_done_pulse", DONE, 0);
    chk("tbl_lv", LV, 200);
    chk("tbl_lvtag", LV_TAG, 3);
    chk("tbl_idle_busy", BUSY, 0);

    // Empty sweep: START then STOP, LV must be retained
    START = 1'b1; tick(); START = 1'b0; STOP = 1'b1; tick(); STOP = 1'b0;
    chk("empty_done", DONE, 1);
    chk("empty_flag", EMPTY, 1);
    tick();
    chk("empty_lv", LV, 200);
    chk("empty_lvtag", LV_TAG, 3);

    // Overflow guard near full scale
    START = 1'b1; tick(); START = 1'b0;
    PV = 12'hFFD; TAG = 8'd9; PV_VALID = 1'b1; tick();
    chk("ovf_first_gt", GT, 1);
    PV = 12'hFFF; TAG = 8'd10; tick();
    chk("ovf_gt", GT, 0);
    chk("ovf_max", MAX_RUN, 12'hFFD);
    PV_VALID = 1'b0; STOP = 1'b1; tick(); STOP = 1'b0;
    tick();
    chk("ovf_lvtag", LV_TAG, 9);
    START = 1'b1; tick(); START = 1'b0;
    PV = 12'h000; TAG = 8'd11; PV_VALID = 1'b1; tick(); PV_VALID = 1'b0;
    chk("zero_first_gt", GT, 1);
    chk("zero_first_max", MAX_RUN, 0);
    STOP = 1'b1; tick(); STOP = 1'b0; tick();
    chk("zero_lv", LV, 0);
    chk("zero_lvtag", LV_TAG, 11);

    // STOP coincident with a capturing sample; START mid-sweep ignored
    START = 1'b1; tick(); START = 1'b0;
    PV = 12'd100; TAG = 8'd1; PV_VALID = 1'b1; tick(); PV_VALID = 1'b0;
    START = 1'b1; tick(); START = 1'b0;
    chk("midstart_busy", BUSY, 1);
    chk("midstart_cnt", SAMPLE_CNT, 1);
    chk("midstart_max", MAX_RUN, 100);
    PV = 12'd900; TAG = 8'd42; PV_VALID = 1'b1; STOP = 1'b1; tick();
    PV_VALID = 1'b0; STOP = 1'b0;
    chk("stop_gt", GT, 1);
    chk("stop_done", DONE, 1);
    chk("stop_cnt", SAMPLE_CNT, 2);
    START = 1'b1; tick(); START = 1'b0;
    chk("stop_lv", LV, 900);
    chk("stop_lvtag", LV_TAG, 42);
    chk("done_start_ignored", BUSY, 0);
    tick();
    chk("done_start_still_idle", BUSY, 0);

    // Async reset mid-sweep after two captures
    START = 1'b1; tick(); START = 1'b0;
    PV = 12'd300; TAG = 8'd7; PV_VALID = 1'b1; tick();
    PV = 12'd400; TAG = 8'd8; tick();
    PV_VALID = 1'b0;
    chk("pre_rst_max", MAX_RUN, 400);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_max", MAX_RUN, 0);
    chk("arst_lv", LV, 0);
    chk("arst_lvtag", LV_TAG, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_cnt", SAMPLE_CNT, 0);
    chk("arst_gt", GT, 0);
    #1 RST_N = 1'b1;
    tick();
    chk("post_rst_busy", BUSY, 0);

    // Random sweeps against a list-based reference model
    m_lv = 0; m_lvtag = 0;
    for (int s = 0; s < 40; s++) begin
      int idle_n;
      bit exited;
      idle_n = $urandom_range(0, 2);
      for (int k = 0; k < idle_n; k++) begin
        PV_VALID = 1'($urandom_range(0, 1));
        PV = WIDTH'($urandom_range(0, 4095));
        STOP = 1'($urandom_range(0, 1));
        tick();
      end
      PV_VALID = 1'b0; STOP = 1'b0;
      START = 1'b1; tick(); START = 1'b0;
      chk("rnd_busy", BUSY, 1);
      m_max = 0; m_tag = 0; m_cnt = 0; exited = 0;
      for (int c = 0; c < 40 && !exited; c++) begin
        bit v, st, cap;
        int pv, tg;
        v  = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) begin
          pv = m_max + int'($urandom_range(0, 2 * HYST + 2));
          if (pv > 4095) pv = 4095;
        end else begin
          pv = int'($urandom_range(0, 4095));
        end
        tg = int'($urandom_range(0, 255));
        st = (c == 39) || ($urandom_range(0, 9) == 0);
        START = 1'($urandom_range(0, 1));
        PV_VALID = v; PV = WIDTH'(pv); TAG = TAG_W'(tg); STOP = st;
        cap = v && ((m_cnt == 0) || (pv > m_max + HYST));
        if (cap) begin m_max = pv; m_tag = tg; end
        if (v) m_cnt++;
        exited = st || (v && m_cnt == SLEN);
        tick();
        chk("rnd_gt", GT, cap);
        chk("rnd_max", MAX_RUN, m_max);
        chk("rnd_done", DONE, exited);
      end
      PV_VALID = 1'b0; STOP = 1'b0; START = 1'b0;
      chk("rnd_empty", EMPTY, (m_cnt == 0));
      chk("rnd_cnt", SAMPLE_CNT, m_cnt);
      if (m_cnt > 0) begin m_lv = m_max; m_lvtag = m_tag; end
      tick();
      chk("rnd_lv", LV, m_lv);
      chk("rnd_lvtag", LV_TAG, m_lvtag);
      chk("rnd_idle", BUSY, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pv_peak_tracker.md
Name: pv_peak_tracker

Overview:
Parametrised successor to the single-register max-voltage store. It captures the peak ADC sample and the tracker position (tag) at which it occurred over a bounded sweep. A hysteresis threshold filters noise, and the result is double-buffered so the committed peak stays stable while a new sweep runs. It sits between the ADC sample stream and the comparator/servo control logic.

Parameters:
WIDTH, 12, ADC sample width in bits
TAG_W, 8, position tag width (servo step index)
CNT_W, 16, sample counter width
SWEEP_LEN, 180, valid samples per sweep; 0 = unlimited (only STOP ends the sweep)
HYST, 4, minimum excess over the running max needed to replace it (unsigned, < 2**WIDTH)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  begin sweep (level sampled each cycle in IDLE)
STOP  in  1  abort/finish sweep early (sampled only in SWEEP)
PV_VALID  in  1  PV/TAG valid this cycle
PV  in  WIDTH  pending ADC value
TAG  in  TAG_W  position associated with PV
MAX_RUN  out  WIDTH  running max of the current sweep
LV  out  WIDTH  committed peak of the last completed non-empty sweep
LV_TAG  out  TAG_W  tag of LV
GT  out  1  one-cycle pulse: the running max was updated
BUSY  out  1  high in SWEEP
DONE  out  1  one-cycle pulse at sweep end
EMPTY  out  1  qualifies DONE: sweep accepted zero samples
SAMPLE_CNT  out  CNT_W  valid samples accepted in the current/last sweep

Behaviour:
- Reset (async, RST_N=0): state IDLE; MAX_RUN, LV, LV_TAG, SAMPLE_CNT = 0; GT, BUSY, DONE, EMPTY = 0. Reset mid-sweep discards all progress.
- All outputs are registered.
- States:
  - IDLE: START=1 -> SWEEP next cycle; clears MAX_RUN, the running tag and SAMPLE_CNT on that transition. PV_VALID is ignored.
  - SWEEP: BUSY=1. On PV_VALID, SAMPLE_CNT increments.
    - First accepted sample (SAMPLE_CNT==0) is captured unconditionally.
    - Later samples are captured iff PV > MAX_RUN + HYST. The compare is done in WIDTH+1 bits, with no wrap.
    - Ties and sub-threshold gains keep the earlier sample and tag.
    - A capture updates MAX_RUN and the running tag at the next edge. GT pulses in that same cycle (1-cycle latency from the PV_VALID edge).
  - SWEEP exit: exits to DONE when the accepted sample makes SAMPLE_CNT == SWEEP_LEN (SWEEP_LEN != 0), or when STOP=1. A sample valid in the same cycle as STOP or as the final count is processed before exit.
  - DONE: lasts exactly one cycle, DONE=1.
    - If SAMPLE_CNT > 0: LV <= MAX_RUN and LV_TAG <= running tag, visible the cycle after DONE. EMPTY=0.
    - Else: LV/LV_TAG are unchanged and EMPTY=1.
    - Always returns to IDLE. START and PV_VALID are ignored in DONE.
- START while in SWEEP is ignored (no restart). STOP in IDLE or DONE is ignored. START and STOP together in IDLE: the sweep starts; STOP is not seen until the next cycle.
- SAMPLE_CNT saturates at 2**CNT_W-1 in unlimited mode and is held after DONE until the next START.
- MAX_RUN is held after DONE until the next START.

Test Plan:
- Reset then idle, with PV_VALID toggling and PV=0xFFF -> LV=0, MAX_RUN=0, GT never pulses, BUSY=0.
- SWEEP_LEN=5, HYST=4; samples (PV,TAG) = (100,0), (103,1), (105,2), (200,3), (204,4):
  - Captures at tags 0, 2 and 3 only, so GT pulses 3 times.
  - DONE pulses the cycle after the 5th sample.
  - LV=200, LV_TAG=3; SAMPLE_CNT=5; EMPTY=0.
- Overflow guard: MAX_RUN=0xFFD with HYST=4, then PV=0xFFF -> no capture and no GT. Then PV=0x000 as the first sample of a new sweep -> captured.
- START then STOP on the next cycle with no valid samples -> DONE with EMPTY=1; LV/LV_TAG retain the previous values (200, 3).
- STOP coincident with PV_VALID carrying PV=900 (> MAX_RUN + HYST) -> sample is captured, then DONE; LV=900. A START pulse during that SWEEP has no effect.
- Assert RST_N=0 mid-sweep after 2 captures -> all outputs return to reset values asynchronously. The next sweep behaves as if from a fresh reset.
